// File: rtl/dff_pkg.sv
// Shared constants and helpers for the dff register family.
package dff_pkg;

    localparam int unsigned DFF_DATA_WIDTH = 32;
    localparam int unsigned DFF_DEPTH      = 2;

    // Width needed to hold an occupancy of 0..depth.
    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dff_pipe_vr_stage.sv
// One valid/data register stage of dff_pipe_vr; enable comes from the handshake.
// Data reset is present only when DFF_PIPE_VR_DATA_RESET_EN is defined.
module dff_pipe_vr_stage
    import dff_pkg::*;
#(
    parameter int unsigned              DATA_WIDTH  = DFF_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0]    RESET_VALUE = '0
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  up_valid,
    input  logic [DATA_WIDTH-1:0] up_data,
    input  logic                  dn_ready,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  rdy
);

    logic                  valid_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  load;

    // An empty stage always accepts, so bubbles collapse under a stall.
    assign rdy  = !valid_q || dn_ready;
    assign load = !flush && rdy && up_valid;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (rdy) begin
            valid_q <= up_valid;
        end
    end

`ifdef DFF_PIPE_VR_DATA_RESET_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= RESET_VALUE;
        end else if (load) begin
            data_q <= up_data;
        end
    end
`else
    logic unused_reset_value;
    assign unused_reset_value = ^RESET_VALUE;

    always_ff @(posedge clock) begin
        if (load) begin
            data_q <= up_data;
        end
    end
`endif

    assign valid = valid_q;
    assign data  = data_q;

endmodule

// File: rtl/dff_pipe_vr.sv
// DEPTH-stage valid/ready pipeline register with flush and occupancy counter.
// Define DFF_PIPE_VR_DATA_RESET_EN to reset the data registers to RESET_VALUE.
module dff_pipe_vr
    import dff_pkg::*;
#(
    parameter int unsigned              DATA_WIDTH  = DFF_DATA_WIDTH,
    parameter int unsigned              DEPTH       = DFF_DEPTH,
    parameter logic [DATA_WIDTH-1:0]    RESET_VALUE = '0
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic                             flush,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [DATA_WIDTH-1:0]            in_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic [count_width(DEPTH)-1:0]    count
);

    localparam int unsigned CW = count_width(DEPTH);

    logic                  valid_s [DEPTH];
    logic [DATA_WIDTH-1:0] data_s  [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic                  up_valid;
        logic [DATA_WIDTH-1:0] up_data;
        logic                  dn_ready;
        // Per-stage ready kept local so the ready chain is not one looped variable.
        logic                  rdy;

        if (i == 0) begin : g_head
            assign up_valid = in_valid;
            assign up_data  = in_data;
        end else begin : g_body
            assign up_valid = valid_s[i-1];
            assign up_data  = data_s[i-1];
        end

        if (i == DEPTH - 1) begin : g_tail
            assign dn_ready = out_ready;
        end else begin : g_mid
            assign dn_ready = g_stage[i+1].rdy;
        end

        dff_pipe_vr_stage #(
            .DATA_WIDTH  (DATA_WIDTH),
            .RESET_VALUE (RESET_VALUE)
        ) u_stage (
            .clock    (clock),
            .reset_n  (reset_n),
            .flush    (flush),
            .up_valid (up_valid),
            .up_data  (up_data),
            .dn_ready (dn_ready),
            .valid    (valid_s[i]),
            .data     (data_s[i]),
            .rdy      (rdy)
        );
    end

    assign in_ready  = g_stage[0].rdy && !flush;
    assign out_valid = valid_s[DEPTH-1] && !flush;
    assign out_data  = data_s[DEPTH-1];

    logic          in_fire;
    logic          out_fire;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (in_fire && !out_fire) begin
            count_d = count_q + 1'b1;
        end else if (out_fire && !in_fire) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_dff_pipe_vr.sv
// Randomised and directed bench for dff_pipe_vr against a slot-movement reference model.
module tb_dff_pipe_vr;

    localparam int unsigned W  = 16;
    localparam int unsigned D  = 3;
    localparam int unsigned CW = $clog2(D + 1);
    localparam logic [W-1:0] RV = 16'hA5C3;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [CW-1:0] count;

    always #5 clock = ~clock;

    dff_pipe_vr #(
        .DATA_WIDTH  (W),
        .DEPTH       (D),
        .RESET_VALUE (RV)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference: slots of the pipeline, each either empty or holding one item.
    bit           m_occ [D];
    logic [W-1:0] m_dat [D];
    logic [W-1:0] sb [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int occupancy(input bit o [D]);
        int n = 0;
        for (int j = 0; j < D; j++) n += int'(o[j]);
        return n;
    endfunction

    task automatic model_clear();
        for (int j = 0; j < D; j++) m_occ[j] = 1'b0;
        sb.delete();
    endtask

    // Called at posedge+1; drives inputs, checks outputs, advances the model over one edge.
    task automatic cycle(input logic v, input logic [W-1:0] d, input logic ordy, input logic fl);
        bit           n_occ [D];
        logic [W-1:0] n_dat [D];
        bit           rdy0;
        bit           ofire;
        logic [W-1:0] exp_d;

        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        #2;

        n_occ = m_occ;
        n_dat = m_dat;
        ofire = m_occ[D-1] && ordy && !fl;
        // Items advance front-to-back into any slot that is empty or being vacated.
        if (ordy) n_occ[D-1] = 1'b0;
        for (int j = D - 2; j >= 0; j--) begin
            if (n_occ[j] && !n_occ[j+1]) begin
                n_occ[j+1] = 1'b1;
                n_dat[j+1] = n_dat[j];
                n_occ[j]   = 1'b0;
            end
        end
        rdy0 = !n_occ[0];

        check_eq("in_ready", in_ready, rdy0 && !fl);
        check_eq("out_valid", out_valid, m_occ[D-1] && !fl);
        check_eq("count", count, occupancy(m_occ));
        if (m_occ[D-1] && !fl) check_eq("out_data", out_data, m_dat[D-1]);
        if (ofire) begin
            if (sb.size() == 0) begin
                check_eq("sb_underflow", 32'd1, 32'd0);
            end else begin
                exp_d = sb.pop_front();
                check_eq("sb_order", out_data, exp_d);
            end
        end

        if (fl) begin
            for (int j = 0; j < D; j++) n_occ[j] = 1'b0;
            sb.delete();
        end else if (v && rdy0) begin
            n_occ[0] = 1'b1;
            n_dat[0] = d;
            sb.push_back(d);
        end

        @(posedge clock);
        #1;
        m_occ = n_occ;
        m_dat = n_dat;
    endtask

    initial begin
        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        model_clear();
        #1;
        check_eq("rst_count", count, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_in_ready", in_ready, 1);
        #11 reset_n = 1'b1;
        @(posedge clock);
        #1;

        // Continuous stream with downstream always ready.
        for (int i = 1; i <= 8; i++) cycle(1'b1, W'(i), 1'b1, 1'b0);
        check_eq("stream_count", count, D);
        for (int i = 0; i < D + 1; i++) cycle(1'b0, '0, 1'b1, 1'b0);

        // Fill under stall, then pass-through ready.
        for (int i = 0; i < D + 1; i++) cycle(1'b1, W'(16'h20 + i), 1'b0, 1'b0);
        check_eq("full_count", count, D);
        check_eq("full_in_ready", in_ready, 0);
        for (int i = 0; i < 4; i++) cycle(1'b1, W'(16'h30 + i), 1'b1, 1'b0);
        check_eq("passthru_count", count, D);
        for (int i = 0; i < D + 1; i++) cycle(1'b0, '0, 1'b1, 1'b0);

        // Bubble collapse under stall.
        cycle(1'b1, 16'h000A, 1'b0, 1'b0);
        cycle(1'b0, 16'hDEAD, 1'b0, 1'b0);
        cycle(1'b1, 16'h000B, 1'b0, 1'b0);
        check_eq("bubble_count", count, 2);
        for (int i = 0; i < D + 1; i++) cycle(1'b0, '0, 1'b1, 1'b0);

        // Flush with a full pipe wins over both handshakes.
        for (int i = 0; i < D; i++) cycle(1'b1, W'(16'h40 + i), 1'b0, 1'b0);
        cycle(1'b1, 16'h0077, 1'b1, 1'b1);
        check_eq("flush_count", count, 0);
        check_eq("flush_out_valid", out_valid, 0);

        // Asynchronous reset mid-stream, between edges.
        for (int i = 0; i < 2; i++) cycle(1'b1, W'(16'h50 + i), 1'b0, 1'b0);
        in_valid  = 1'b0;
        flush     = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check_eq("arst_count", count, 0);
        check_eq("arst_out_valid", out_valid, 0);
`ifdef DFF_PIPE_VR_DATA_RESET_EN
        check_eq("arst_out_data", out_data, RV);
`endif
        model_clear();
        #2 reset_n = 1'b1;
        @(posedge clock);
        #1;

        // Random valid/ready with occasional flush.
        for (int i = 0; i < 3000; i++) begin
            cycle(1'($urandom_range(0, 1)), W'($urandom),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 40) == 0));
        end
        for (int i = 0; i < D + 1; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        check_eq("final_count", count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
